// File: rtl/imem_load_ctrl_if.sv
// imem_load_ctrl_if
//   Groups the controller's load handshake, CPU fetch and memory port signals.
//   master : environment side (loader source, CPU, memory)
//   slave  : imem_load_ctrl side
//   Signals: load_start, load_len[15:0], rx_data[7:0], rx_valid, rx_ready,
//            cpu_pc[31:0], cpu_instr[31:0], cpu_stall, mem_addr[AW-1:0],
//            mem_we, mem_wdata[31:0], mem_rdata[31:0], busy, done, error,
//            checksum[31:0] (only when IMEM_LOAD_CHECKSUM_EN is defined).
interface imem_load_ctrl_if #(
  parameter int MEM_SIZE = 128
);
  localparam int AW = $clog2(MEM_SIZE);

  logic          load_start;
  logic [15:0]   load_len;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [31:0]   cpu_pc;
  logic [31:0]   cpu_instr;
  logic          cpu_stall;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          busy;
  logic          done;
  logic          error;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0]   checksum;

  modport master (
    output load_start, load_len, rx_data, rx_valid, cpu_pc, mem_rdata,
    input  rx_ready, cpu_instr, cpu_stall, mem_addr, mem_we, mem_wdata,
           busy, done, error, checksum
  );

  modport slave (
    input  load_start, load_len, rx_data, rx_valid, cpu_pc, mem_rdata,
    output rx_ready, cpu_instr, cpu_stall, mem_addr, mem_we, mem_wdata,
           busy, done, error, checksum
  );
`else
  modport master (
    output load_start, load_len, rx_data, rx_valid, cpu_pc, mem_rdata,
    input  rx_ready, cpu_instr, cpu_stall, mem_addr, mem_we, mem_wdata,
           busy, done, error
  );

  modport slave (
    input  load_start, load_len, rx_data, rx_valid, cpu_pc, mem_rdata,
    output rx_ready, cpu_instr, cpu_stall, mem_addr, mem_we, mem_wdata,
           busy, done, error
  );
`endif
endinterface

// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl
//   Owns the single instruction-memory port. In IDLE the CPU PC is passed
//   through as a word address and the read word returned; during a load the
//   CPU is stalled and a byte stream is packed little-endian into 32-bit
//   words written from word 0 upward.
// Ports
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   bus    : imem_load_ctrl_if.slave (load handshake, CPU fetch, memory port,
//            busy/done/error status)
// Optional feature
//   IMEM_LOAD_CHECKSUM_EN : adds bus.checksum, the mod-2^32 sum of every word
//                           written in the current load session.
//
// state | meaning
// IDLE  | CPU owns memory; waiting for load_start
// RECV  | CPU stalled; collecting bytes of the current word
// WRITE | one-cycle write of the assembled word
// DONE  | one-cycle completion pulse; CPU released
module imem_load_ctrl #(
  parameter int MEM_SIZE = 128,
  parameter int TIMEOUT  = 1023
) (
  input  logic clk,
  input  logic rst_n,
  imem_load_ctrl_if.slave bus
);
  localparam int AW = $clog2(MEM_SIZE);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t        state, state_nxt;
  logic [15:0]   len_q;
  logic [AW-1:0] word_addr;
  logic [1:0]    byte_cnt;
  logic [31:0]   wbuf;
  logic [TW-1:0] idle_tmr;
  logic          error_q;
  logic          zdone_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0]   checksum_q;
`endif

  logic start_ok, len_zero, len_big, accept, last_word, timeout;

  assign start_ok  = (state == IDLE) && bus.load_start;
  assign len_zero  = (bus.load_len == 16'd0);
  assign len_big   = 32'(bus.load_len) > 32'(MEM_SIZE);
  assign accept    = (state == RECV) && bus.rx_valid;
  assign last_word = 32'(word_addr) == (32'(len_q) - 32'd1);
  // idle_tmr counts down the idle cycles still allowed; the cycle that sees
  // 1 left without a byte is the TIMEOUT-th idle cycle.
  assign timeout   = (state == RECV) && !bus.rx_valid && (idle_tmr <= TW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.rx_ready  = 1'b0;
    bus.mem_we    = 1'b0;
    bus.cpu_stall = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = zdone_q;
    bus.cpu_instr = NOP;
    bus.mem_addr  = word_addr;
    bus.mem_wdata = wbuf;
    case (state)
      IDLE: begin
        bus.mem_addr  = bus.cpu_pc[AW+1:2];
        bus.cpu_instr = bus.mem_rdata;
        if (start_ok && !len_zero && !len_big) state_nxt = RECV;
      end
      RECV: begin
        bus.busy      = 1'b1;
        bus.cpu_stall = 1'b1;
        bus.rx_ready  = 1'b1;
        if (timeout)                              state_nxt = IDLE;
        else if (accept && (byte_cnt == 2'd3))   state_nxt = WRITE;
      end
      WRITE: begin
        bus.busy      = 1'b1;
        bus.cpu_stall = 1'b1;
        bus.mem_we    = 1'b1;
        state_nxt     = last_word ? DONE : RECV;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q      <= '0;
      word_addr  <= '0;
      byte_cnt   <= '0;
      wbuf       <= '0;
      idle_tmr   <= '0;
      error_q    <= 1'b0;
      zdone_q    <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      checksum_q <= '0;
`endif
    end else begin
      zdone_q <= start_ok && len_zero;
      if (start_ok) begin
        // Oversize requests are flagged here and never leave IDLE.
        error_q    <= len_big;
        len_q      <= bus.load_len;
        word_addr  <= '0;
        byte_cnt   <= '0;
        idle_tmr   <= TW'(TIMEOUT);
`ifdef IMEM_LOAD_CHECKSUM_EN
        checksum_q <= '0;
`endif
      end else begin
        case (state)
          RECV: begin
            if (accept) begin
              wbuf[{byte_cnt, 3'b000} +: 8] <= bus.rx_data;
              byte_cnt <= byte_cnt + 2'd1;
              idle_tmr <= TW'(TIMEOUT);
            end else if (timeout) begin
              error_q <= 1'b1;
            end else begin
              idle_tmr <= idle_tmr - TW'(1);
            end
          end
          WRITE: begin
            byte_cnt <= '0;
            idle_tmr <= TW'(TIMEOUT);
            // Hold on the last word so the address never wraps.
            if (!last_word) word_addr <= word_addr + AW'(1);
`ifdef IMEM_LOAD_CHECKSUM_EN
            checksum_q <= checksum_q + wbuf;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.error = error_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
  assign bus.checksum = checksum_q;
`endif

endmodule

// File: tb/tb_imem_load_ctrl.sv
module tb_imem_load_ctrl;
  localparam int MEM_SIZE = 128;
  localparam int TIMEOUT  = 1023;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic preload = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   we_cnt = 0;
  int   done_cnt = 0;
  int   we0, d0;

  logic [31:0] mem [MEM_SIZE];

  imem_load_ctrl_if #(.MEM_SIZE(MEM_SIZE)) bus ();

  imem_load_ctrl #(.MEM_SIZE(MEM_SIZE), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < MEM_SIZE; i++) mem[i] <= 32'hA000_0000 | 32'(i);
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    if (bus.mem_we) we_cnt <= we_cnt + 1;
    if (bus.done)   done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_load(input logic [15:0] len);
    bus.load_len   = len;
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("rx_ready_wait", 32'(bus.rx_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  initial begin
    bus.load_start = 1'b0;
    bus.load_len   = 16'd0;
    bus.rx_data    = 8'd0;
    bus.rx_valid   = 1'b0;
    bus.cpu_pc     = 32'h0000_0008;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_busy",  32'(bus.busy), 32'd0);
    check("rst_ready", 32'(bus.rx_ready), 32'd0);
    check("rst_we",    32'(bus.mem_we), 32'd0);
    preload = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // 1. fetch pass-through
    check("t1_addr",  32'(bus.mem_addr), 32'd2);
    check("t1_instr", bus.cpu_instr, 32'hA000_0002);
    check("t1_stall", 32'(bus.cpu_stall), 32'd0);
    check("t1_done",  32'(bus.done), 32'd0);
    check("t1_error", 32'(bus.error), 32'd0);
    bus.cpu_pc = 32'h0000_01FC;
    #1;
    check("t1_addr_top",  32'(bus.mem_addr), 32'd127);
    check("t1_instr_top", bus.cpu_instr, 32'hA000_007F);

    // 2. two-word load
    we0 = we_cnt; d0 = done_cnt;
    start_load(16'd2);
    check("t2_busy",  32'(bus.busy), 32'd1);
    check("t2_stall", 32'(bus.cpu_stall), 32'd1);
    check("t2_nop",   bus.cpu_instr, 32'h0000_0013);
    check("t2_ready", 32'(bus.rx_ready), 32'd1);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    check("t2_wr_we",    32'(bus.mem_we), 32'd1);
    check("t2_wr_addr",  32'(bus.mem_addr), 32'd1);
    check("t2_wr_data",  bus.mem_wdata, 32'h0010_0093);
    check("t2_wr_ready", 32'(bus.rx_ready), 32'd0);
    @(negedge clk);
    check("t2_done",       32'(bus.done), 32'd1);
    check("t2_done_busy",  32'(bus.busy), 32'd0);
    check("t2_done_stall", 32'(bus.cpu_stall), 32'd0);
    @(negedge clk);
    check("t2_done_off", 32'(bus.done), 32'd0);
    check("t2_mem0", mem[0], 32'h0000_0013);
    check("t2_mem1", mem[1], 32'h0010_0093);
    check("t2_we_count",   32'(we_cnt - we0), 32'd2);
    check("t2_done_count", 32'(done_cnt - d0), 32'd1);
`ifdef IMEM_LOAD_CHECKSUM_EN
    check("t2_checksum", bus.checksum, 32'h0010_00A6);
`endif
    bus.cpu_pc = 32'h0000_0004;
    #1;
    check("t2_fetch", bus.cpu_instr, 32'h0010_0093);

    // 3. zero-length load
    we0 = we_cnt;
    start_load(16'd0);
    check("t3_done", 32'(bus.done), 32'd1);
    check("t3_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("t3_done_off", 32'(bus.done), 32'd0);
    check("t3_busy2",    32'(bus.busy), 32'd0);
    check("t3_no_we",    32'(we_cnt - we0), 32'd0);

    // 4. oversize load, then a valid one clears the error
    we0 = we_cnt;
    start_load(16'd200);
    check("t4_error", 32'(bus.error), 32'd1);
    check("t4_busy",  32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    check("t4_error_sticky", 32'(bus.error), 32'd1);
    check("t4_no_we", 32'(we_cnt - we0), 32'd0);
    start_load(16'd129);
    check("t4_error_129", 32'(bus.error), 32'd1);
    check("t4_busy_129",  32'(bus.busy), 32'd0);
    d0 = done_cnt;
    start_load(16'd1);
    check("t4_error_clr", 32'(bus.error), 32'd0);
    check("t4_busy1",     32'(bus.busy), 32'd1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    repeat (2) @(negedge clk);
    check("t4_mem0",  mem[0], 32'h4433_2211);
    check("t4_done",  32'(done_cnt - d0), 32'd1);
    check("t4_error2", 32'(bus.error), 32'd0);
`ifdef IMEM_LOAD_CHECKSUM_EN
    check("t4_checksum", bus.checksum, 32'h4433_2211);
`endif

    // 5. timeout with a partial word
    we0 = we_cnt;
    start_load(16'd1);
    send_byte(8'hAA); send_byte(8'hBB);
    repeat (TIMEOUT - 5) @(negedge clk);
    check("t5_still_busy", 32'(bus.busy), 32'd1);
    check("t5_no_err_yet", 32'(bus.error), 32'd0);
    repeat (7) @(negedge clk);
    check("t5_error", 32'(bus.error), 32'd1);
    check("t5_busy",  32'(bus.busy), 32'd0);
    check("t5_ready", 32'(bus.rx_ready), 32'd0);
    check("t5_no_we", 32'(we_cnt - we0), 32'd0);
    check("t5_mem0",  mem[0], 32'h4433_2211);
`ifdef IMEM_LOAD_CHECKSUM_EN
    check("t5_checksum", bus.checksum, 32'h0);
`endif

    // 6. reset in the middle of a load
    we0 = we_cnt;
    start_load(16'd4);
    check("t6_error_clr", 32'(bus.error), 32'd0);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h04); send_byte(8'h05); send_byte(8'h06);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_busy",  32'(bus.busy), 32'd0);
    check("t6_error", 32'(bus.error), 32'd0);
    check("t6_stall", 32'(bus.cpu_stall), 32'd0);
    repeat (4) @(negedge clk);
    check("t6_we_count", 32'(we_cnt - we0), 32'd1);
    check("t6_mem0", mem[0], 32'h0403_0201);
    check("t6_mem1", mem[1], 32'h0010_0093);
    bus.cpu_pc = 32'h0000_0000;
    #1;
    check("t6_fetch", bus.cpu_instr, 32'h0403_0201);
`ifdef IMEM_LOAD_CHECKSUM_EN
    check("t6_checksum", bus.checksum, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
